gray2bin_stream: RTL and testbench

Streaming Gray-to-binary decoder with a ready/valid interface on both sides and a registered output stage. It is the receive-side counterpart of `bin2gray`: it accepts Gray-coded counter values, such as pointers or encoder positions, and returns their binary value one cycle later. An optional step monitor flags any accepted value that is not exactly one Gray step from the previous accepted value, and counts such violations.

---
 rtl/gray_pkg.sv | 41 ++++
 rtl/gray2bin.sv | 21 ++
 rtl/gray2bin_stream.sv | 121 ++++++++++++
 tb/tb_gray2bin_stream.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// -----------------------------------------------------------------------------
// gray_pkg
//   Shared definitions for the Gray-code blocks (bin2gray, gray2bin,
//   gray2bin_stream).
//   - gray_default_width_c : default Gray/binary word width.
//   - gray_max_width_c     : widest word the helper function handles.
//   - gray_mon_state_e     : step-monitor states {EMPTY, TRACK}.
//   - gray2bin_f           : Gray-to-binary decode, bounded by a width arg.
// -----------------------------------------------------------------------------
package gray_pkg;

  localparam int gray_default_width_c = 5;
  localparam int gray_max_width_c     = 32;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    TRACK = 1'b1
  } gray_mon_state_e;

  // Each binary bit is the XOR of every Gray bit at or above it. Bits at or
  // above 'width' are left zero, so callers zero-extend narrower words.
  function automatic logic [gray_max_width_c-1:0] gray2bin_f(
    input logic [gray_max_width_c-1:0] gray,
    input int                          width
  );
    logic [gray_max_width_c-1:0] bin;
    logic                        acc;
    // NOTE: function locals are plain variables, so blocking '=' is correct
    // here; only clocked state in always_ff uses '<='.
    bin = '0;
    acc = 1'b0;
    for (int i = gray_max_width_c - 1; i >= 0; i--) begin
      if (i < width) begin
        acc    = acc ^ gray[i];
        bin[i] = acc;
      end
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray2bin.sv
// -----------------------------------------------------------------------------
// gray2bin
//   Purely combinational Gray-to-binary decoder wrapping gray_pkg::gray2bin_f.
//   Reusable anywhere a Gray word needs decoding.
//   Parameters: width_p - word width (>= 2).
//   Ports:
//     gray_i [width_p-1:0] in  : Gray-coded word.
//     bin_o  [width_p-1:0] out : binary value of gray_i.
// -----------------------------------------------------------------------------
module gray2bin
  import gray_pkg::*;
#(
  parameter int width_p = gray_default_width_c
) (
  input  logic [width_p-1:0] gray_i,
  output logic [width_p-1:0] bin_o
);

  assign bin_o = width_p'(gray2bin_f(gray_max_width_c'(gray_i), width_p));

endmodule

// File: rtl/gray2bin_stream.sv
// -----------------------------------------------------------------------------
// gray2bin_stream
//   Streaming Gray-to-binary decoder with ready/valid on both sides and a
//   single registered output stage (full-throughput pass-through).
//   Optional step monitor, enabled by defining GRAY2BIN_STREAM_MONITOR_EN:
//   flags any accepted sample that is not exactly one bit flip away from the
//   previously accepted sample and counts such events (saturating). With the
//   macro undefined, step_err_o and err_count_o are constant 0.
//
//   Parameters:
//     width_p         - Gray/binary word width (>= 2).
//     err_cnt_width_p - width of the saturating step-error counter.
//   Ports:
//     clk_i        in  : clock, rising edge.
//     reset_i      in  : synchronous active-high reset.
//     valid_i      in  : gray_i carries a sample.
//     gray_i       in  : Gray-coded sample.
//     ready_o      out : sample can be accepted this cycle.
//     valid_o      out : bin_o carries a decoded result.
//     bin_o        out : decoded binary value.
//     step_err_o   out : result failed the step check (qualified by valid_o).
//     ready_i      in  : downstream accepts the result.
//     err_count_o  out : step errors since reset, saturating.
// -----------------------------------------------------------------------------
module gray2bin_stream
  import gray_pkg::*;
#(
  parameter int width_p         = gray_default_width_c,
  parameter int err_cnt_width_p = 8
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       valid_i,
  input  logic [width_p-1:0]         gray_i,
  output logic                       ready_o,
  output logic                       valid_o,
  output logic [width_p-1:0]         bin_o,
  output logic                       step_err_o,
  input  logic                       ready_i,
  output logic [err_cnt_width_p-1:0] err_count_o
);

  logic               accept;
  logic [width_p-1:0] bin_dec;
  logic               step_err_next;

  // The output register can take a new word when empty, or when its current
  // word leaves this same cycle.
  assign ready_o = ~valid_o | ready_i;
  assign accept  = valid_i & ready_o;

  gray2bin #(
    .width_p (width_p)
  ) u_gray2bin (
    .gray_i (gray_i),
    .bin_o  (bin_dec)
  );

`ifdef GRAY2BIN_STREAM_MONITOR_EN

  localparam logic [0:0] ST_EMPTY = EMPTY;
  localparam logic [0:0] ST_TRACK = TRACK;

  logic [0:0]                 mon_state;
  logic [width_p-1:0]         prev_gray;
  logic [err_cnt_width_p-1:0] err_cnt;
  logic [width_p-1:0]         diff;
  logic                       one_step;

  // Exactly one differing bit <=> diff is non-zero and a power of two.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned; that is what keeps a latch from being inferred.
    diff          = gray_i ^ prev_gray;
    one_step      = (diff != '0) && ((diff & (diff - 1'b1)) == '0);
    step_err_next = 1'b0;
    if (mon_state == ST_TRACK) begin
      step_err_next = ~one_step;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      mon_state <= ST_EMPTY;
      prev_gray <= '0;
      err_cnt   <= '0;
    end else if (accept) begin
      mon_state <= ST_TRACK;
      prev_gray <= gray_i;
      if (step_err_next && !(&err_cnt)) begin
        err_cnt <= err_cnt + 1'b1;
      end
    end
  end

  assign err_count_o = err_cnt;

`else

  assign step_err_next = 1'b0;
  assign err_count_o   = '0;

`endif

  // Output stage: load on accept, otherwise a drained word just drops valid.
  // bin_o/step_err_o keep their value until the next accept.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_o    <= 1'b0;
      bin_o      <= '0;
      step_err_o <= 1'b0;
    end else if (accept) begin
      valid_o    <= 1'b1;
      bin_o      <= bin_dec;
      step_err_o <= step_err_next;
    end else if (ready_i) begin
      valid_o    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gray2bin_stream.sv
// -----------------------------------------------------------------------------
// tb_gray2bin_stream
//   Bench for gray2bin_stream (width 5, 2-bit error counter). A reference model
//   derived from the stream rules predicts every output each cycle; directed
//   literal expectations pin key points. Monitor expectations follow
//   GRAY2BIN_STREAM_MONITOR_EN.
// -----------------------------------------------------------------------------
module tb_gray2bin_stream;

  localparam int W  = 5;
  localparam int CW = 2;
`ifdef GRAY2BIN_STREAM_MONITOR_EN
  localparam bit MON = 1'b1;
`else
  localparam bit MON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_i;
  logic          valid_i;
  logic [W-1:0]  gray_i;
  logic          ready_o;
  logic          valid_o;
  logic [W-1:0]  bin_o;
  logic          step_err_o;
  logic          ready_i;
  logic [CW-1:0] err_count_o;

  gray2bin_stream #(
    .width_p         (W),
    .err_cnt_width_p (CW)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .valid_i     (valid_i),
    .gray_i      (gray_i),
    .ready_o     (ready_o),
    .valid_o     (valid_o),
    .bin_o       (bin_o),
    .step_err_o  (step_err_o),
    .ready_i     (ready_i),
    .err_count_o (err_count_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] to_gray(input int b);
    return W'(b ^ (b >> 1));
  endfunction

  // Decode by searching for the binary value whose Gray code matches.
  function automatic int from_gray(input logic [W-1:0] g);
    for (int b = 0; b < (1 << W); b++) begin
      if (to_gray(b) == g) return b;
    end
    return -1;
  endfunction

  // ---------------- reference model ----------------
  bit           m_ok    = 1'b0;
  bit           m_valid = 1'b0;
  bit           m_err   = 1'b0;
  bit           m_track = 1'b0;
  bit           m_rdy;
  bit           m_step;
  int           m_bin   = 0;
  int           m_cnt   = 0;
  logic [W-1:0] m_prev  = '0;

  always @(posedge clk) begin
    m_rdy = !m_valid || ready_i;
    if (reset_i) begin
      m_ok    = 1'b1;
      m_valid = 1'b0;
      m_err   = 1'b0;
      m_track = 1'b0;
      m_bin   = 0;
      m_cnt   = 0;
      m_prev  = '0;
    end else if (valid_i && m_rdy) begin
      m_step  = MON && m_track && ($countones(gray_i ^ m_prev) != 1);
      m_valid = 1'b1;
      m_bin   = from_gray(gray_i);
      m_err   = m_step;
      if (m_step && m_cnt < (1 << CW) - 1) m_cnt++;
      m_track = 1'b1;
      m_prev  = gray_i;
    end else if (ready_i) begin
      m_valid = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      check("cyc_valid_o", 32'(valid_o), 32'(m_valid));
      check("cyc_ready_o", 32'(ready_o), 32'(!m_valid || ready_i));
      check("cyc_err_count_o", 32'(err_count_o), 32'(m_cnt));
      if (m_valid) begin
        check("cyc_bin_o", 32'(bin_o), 32'(m_bin));
        check("cyc_step_err_o", 32'(step_err_o), 32'(m_err));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_i = 1'b1;
    valid_i = 1'b0;
    gray_i  = '0;
    ready_i = 1'b1;
    tick();
    tick();
    check("rst_valid_o", 32'(valid_o), 0);
    check("rst_bin_o", 32'(bin_o), 0);
    check("rst_step_err_o", 32'(step_err_o), 0);
    check("rst_err_count_o", 32'(err_count_o), 0);
    check("rst_ready_o", 32'(ready_o), 1);
    reset_i = 1'b0;

    // Exhaustive decode at full throughput.
    for (int b = 0; b < 32; b++) begin
      valid_i = 1'b1;
      gray_i  = to_gray(b);
      tick();
      if (b == 0) begin
        check("lat_valid_o", 32'(valid_o), 1);
        check("lat_bin_o", 32'(bin_o), 0);
      end
    end
    check("seq_bin_31", 32'(bin_o), 31);
    check("seq_step_err", 32'(step_err_o), 0);
    check("seq_err_count", 32'(err_count_o), 0);

    // Wrap 31 -> 0 is a single bit flip.
    gray_i = 5'b00000;
    tick();
    check("wrap_bin", 32'(bin_o), 0);
    check("wrap_step_err", 32'(step_err_o), 0);

    // Legal walk to 5, then jump to 9, then repeat 9.
    for (int b = 1; b <= 5; b++) begin
      gray_i = to_gray(b);
      tick();
    end
    gray_i = to_gray(9);
    tick();
    check("jump_bin", 32'(bin_o), 9);
    check("jump_step_err", 32'(step_err_o), 32'(MON));
    check("jump_count", 32'(err_count_o), MON ? 1 : 0);
    tick();
    check("repeat_step_err", 32'(step_err_o), 32'(MON));
    check("repeat_count", 32'(err_count_o), MON ? 2 : 0);

    // Backpressure: output holds, input stalls.
    ready_i = 1'b0;
    gray_i  = to_gray(10);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_ready_o", 32'(ready_o), 0);
      check("bp_valid_o", 32'(valid_o), 1);
      check("bp_bin_hold", 32'(bin_o), 9);
    end
    ready_i = 1'b1;
    tick();
    check("bp_release_bin", 32'(bin_o), 10);
    check("bp_release_valid", 32'(valid_o), 1);
    check("bp_release_step_err", 32'(step_err_o), 0);

    // Five repeats of the same value: counter must saturate at 3.
    repeat (5) tick();
    check("sat_count", 32'(err_count_o), MON ? 3 : 0);

    // Drain with no new input.
    valid_i = 1'b0;
    tick();
    check("drain_valid_o", 32'(valid_o), 0);
    tick();

    // Reset mid-stream, with a sample presented during reset.
    valid_i = 1'b1;
    gray_i  = to_gray(11);
    tick();
    check("pre_rst_valid_o", 32'(valid_o), 1);
    reset_i = 1'b1;
    gray_i  = to_gray(3);
    tick();
    check("mid_rst_valid_o", 32'(valid_o), 0);
    check("mid_rst_count", 32'(err_count_o), 0);
    reset_i = 1'b0;
    gray_i  = to_gray(20);
    tick();
    check("post_rst_bin", 32'(bin_o), 20);
    check("post_rst_valid", 32'(valid_o), 1);
    check("post_rst_step_err", 32'(step_err_o), 0);
    valid_i = 1'b0;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
